// File: rtl/packet_pkg.sv
// Shared packet transport definitions: packet layout, header tag, FIFO sizing
// and handshake state encoding.
package packet_pkg;

   localparam int unsigned PW     = 38;
   localparam int unsigned DEPTH  = 20;
   localparam int unsigned AW     = $clog2(DEPTH);

   localparam int unsigned HDR_W  = 3;
   localparam int unsigned GEN_W  = 8;
   localparam int unsigned DEST_W = 7;
   localparam int unsigned FLAG_W = 4;
   localparam int unsigned DATA_W = 16;

   localparam int unsigned HDR_LSB  = 35;
   localparam int unsigned GEN_LSB  = 27;
   localparam int unsigned DEST_LSB = 20;
   localparam int unsigned FLAG_LSB = 16;
   localparam int unsigned DATA_LSB = 0;

   localparam logic [HDR_W-1:0] HDR_OK = 3'b111;

   typedef struct packed {
      logic [HDR_W-1:0]  hdr;
      logic [GEN_W-1:0]  gen;
      logic [DEST_W-1:0] dest;
      logic [FLAG_W-1:0] flags;
      logic [DATA_W-1:0] data;
   } packet_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STALL = 2'd1,
      ACK   = 2'd2
   } state_t;

   // Circular pointer advance over DEPTH entries.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

endpackage

// File: rtl/packet_sink_if.sv
// Sender handshake plus host pop port of the packet sink.
import packet_pkg::*;

interface packet_sink_if;
   logic    Send_in;
   packet_t PACKET_IN;
   logic    Ack_out;
   logic    rd_en;
   packet_t rd_data;
   logic    empty;

   modport master (
      output Send_in, PACKET_IN, rd_en,
      input  Ack_out, rd_data, empty
   );

   modport slave (
      input  Send_in, PACKET_IN, rd_en,
      output Ack_out, rd_data, empty
   );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through packet FIFO with occupancy count and flags.
import packet_pkg::*;

module sync_fifo (
   input  logic          CLK,
   input  logic          RST,
   input  logic          wr_en,
   input  packet_t       wr_data,
   input  logic          rd_en,
   output packet_t       rd_data,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count
);

   localparam int unsigned CW = AW + 1;

   packet_t         mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count_n;
   logic            do_wr;
   logic            do_rd;

   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;

   always_comb begin
      count_n = count;
      case ({do_wr, do_rd})
         2'b10:   count_n = count + CW'(1);
         2'b01:   count_n = count - CW'(1);
         default: count_n = count;
      endcase
   end

   // Flags are registered alongside the count they derive from.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
         if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
         count <= count_n;
         empty <= (count_n == '0);
         full  <= (count_n == CW'(DEPTH));
      end
   end

   always_ff @(posedge CLK) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/packet_sink.sv
// Receive end of the packet transport: 4-phase capture into a FIFO with
// header screening and accept/drop bookkeeping.
import packet_pkg::*;

module packet_sink (
   input  logic          CLK,
   input  logic          RST,
   packet_sink_if.slave  bus,
   output logic          full,
   output logic [AW:0]   count,
   output logic          hdr_err,
   output logic [15:0]   pkt_total
);

   state_t state_q, state_n;
   logic   s1, s2, s3;
   logic   rise;
   logic   hdr_ok;
   logic   wr_en;
   logic   err_set;
   logic   ack_n;
   logic   ack_q;

   // Synchroniser resets high so a request held through reset looks stale.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= bus.Send_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise   = s2 & ~s3;
   assign hdr_ok = (bus.PACKET_IN.hdr == HDR_OK);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         ack_q     <= 1'b0;
         hdr_err   <= 1'b0;
         pkt_total <= '0;
      end else begin
         state_q <= state_n;
         ack_q   <= ack_n;
         if (err_set) hdr_err   <= 1'b1;
         if (wr_en)   pkt_total <= pkt_total + 16'd1;
      end
   end

   // Bad headers are acknowledged and dropped; good ones wait for space.
   always_comb begin
      state_n = state_q;
      ack_n   = 1'b0;
      wr_en   = 1'b0;
      err_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) begin
               if (!hdr_ok) begin
                  err_set = 1'b1;
                  ack_n   = 1'b1;
                  state_n = ACK;
               end else if (!full) begin
                  wr_en   = 1'b1;
                  ack_n   = 1'b1;
                  state_n = ACK;
               end else begin
                  state_n = STALL;
               end
            end
         end
         STALL: begin
            if (!full) begin
               wr_en   = 1'b1;
               ack_n   = 1'b1;
               state_n = ACK;
            end
         end
         ACK: begin
            if (s2) begin
               ack_n = 1'b1;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.Ack_out = ack_q;

   sync_fifo u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (wr_en),
      .wr_data (bus.PACKET_IN),
      .rd_en   (bus.rd_en),
      .rd_data (bus.rd_data),
      .empty   (bus.empty),
      .full    (full),
      .count   (count)
   );

endmodule

// File: tb/tb_packet_sink.sv
// Self-checking bench for packet_sink: vector table, corner sequences and a
// randomized stream scored against a queue model.
import packet_pkg::*;

module tb_packet_sink;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          full;
   logic          hdr_err;
   logic [AW:0]   count;
   logic [15:0]   pkt_total;

   packet_sink_if bus();

   packet_sink dut (
      .CLK       (CLK),
      .RST       (RST),
      .bus       (bus.slave),
      .full      (full),
      .count     (count),
      .hdr_err   (hdr_err),
      .pkt_total (pkt_total)
   );

   always #5 CLK = ~CLK;

   int unsigned total_n = 0;
   int unsigned bad_n   = 0;

   packet_t     model_q[$];
   int unsigned model_total;
   bit          model_err;

   typedef struct {
      packet_t     pkt;
      int unsigned exp_count;
      int unsigned exp_total;
      bit          exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_n++;
      if (act !== exp) begin
         bad_n++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic packet_t mk(input logic [2:0] h, input logic [7:0] g, input logic [6:0] d,
                                  input logic [3:0] f, input logic [15:0] dt);
      return {h, g, d, f, dt};
   endfunction

   function automatic packet_t rnd_pkt();
      logic [2:0] h;
      h = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 6)) : HDR_OK;
      return mk(h, 8'($urandom), 7'($urandom), 4'($urandom), 16'($urandom));
   endfunction

   task automatic model_clear();
      model_q.delete();
      model_total = 0;
      model_err   = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      model_clear();
      @(negedge CLK);
   endtask

   // Full 4-phase transaction; records the packet in the model once acknowledged.
   task automatic send(input packet_t p, output bit ok);
      ok = 1'b0;
      bus.PACKET_IN = p;
      bus.Send_in   = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge CLK);
         ok = bus.Ack_out;
      end
      if (ok) begin
         if (p.hdr == HDR_OK) begin
            model_q.push_back(p);
            model_total++;
         end else begin
            model_err = 1'b1;
         end
      end
      bus.Send_in = 1'b0;
      for (int i = 0; i < 20 && bus.Ack_out; i++) @(negedge CLK);
      check("ack_release", 64'(bus.Ack_out), 64'(0));
   endtask

   task automatic pop_check(input string name);
      if (model_q.size() == 0) begin
         check({name, "_empty"}, 64'(bus.empty), 64'(1));
      end else begin
         check(name, 64'(bus.rd_data), 64'(model_q[0]));
         void'(model_q.pop_front());
      end
      bus.rd_en = 1'b1;
      @(negedge CLK);
      bus.rd_en = 1'b0;
   endtask

   initial begin
      bit          ok;
      packet_t     p;
      int          sstate;
      int          sent;
      int          cyc;
      packet_t     cur;

      bus.Send_in   = 1'b0;
      bus.rd_en     = 1'b0;
      bus.PACKET_IN = '0;
      #1 RST = 1'b1;
      model_clear();
      repeat (2) @(negedge CLK);

      check("rst_ack",   64'(bus.Ack_out), 64'(0));
      check("rst_count", 64'(count),       64'(0));
      check("rst_empty", 64'(bus.empty),   64'(1));
      check("rst_full",  64'(full),        64'(0));
      check("rst_err",   64'(hdr_err),     64'(0));
      check("rst_total", 64'(pkt_total),   64'(0));
      check("rst_rdata", 64'(bus.rd_data), 64'(0));
      RST = 1'b0;
      @(negedge CLK);

      // Vector table: ordered good packets, one bad header, then good again.
      vecs[0] = '{mk(3'b111, 8'd0, 7'd0, 4'b0000, 16'd0), 1, 1, 1'b0};
      vecs[1] = '{mk(3'b111, 8'd0, 7'd7, 4'b0101, 16'd1), 2, 2, 1'b0};
      vecs[2] = '{mk(3'b111, 8'd0, 7'd7, 4'b1101, 16'd2), 3, 3, 1'b0};
      vecs[3] = '{mk(3'b111, 8'd0, 7'd1, 4'b0100, 16'd3), 4, 4, 1'b0};
      vecs[4] = '{mk(3'b011, 8'd9, 7'd2, 4'b0001, 16'd4), 4, 4, 1'b1};
      vecs[5] = '{mk(3'b111, 8'h5a, 7'd3, 4'b1111, 16'hbeef), 5, 5, 1'b1};
      for (int i = 0; i < 6; i++) begin
         send(vecs[i].pkt, ok);
         check($sformatf("vec%0d_ack", i),   64'(ok),        64'(1));
         check($sformatf("vec%0d_count", i), 64'(count),     64'(vecs[i].exp_count));
         check($sformatf("vec%0d_total", i), 64'(pkt_total), 64'(vecs[i].exp_total));
         check($sformatf("vec%0d_err", i),   64'(hdr_err),   64'(vecs[i].exp_err));
      end
      for (int i = 0; i < 5; i++) pop_check($sformatf("vec_pop%0d", i));
      check("vec_drained", 64'(bus.empty), 64'(1));
      pop_check("vec_pop_empty");
      check("vec_count_after_empty_pop", 64'(count), 64'(0));

      // Fill to DEPTH, then a stalled request released by one pop.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         send(mk(3'b111, 8'(i), 7'(i), 4'(i), 16'($urandom)), ok);
         check($sformatf("fill%0d_ack", i), 64'(ok), 64'(1));
      end
      check("fill_full",  64'(full),  64'(1));
      check("fill_count", 64'(count), 64'(20));
      p = mk(3'b111, 8'd21, 7'd21, 4'd5, 16'h2121);
      bus.PACKET_IN = p;
      bus.Send_in   = 1'b1;
      repeat (10) @(negedge CLK);
      check("stall_ack",   64'(bus.Ack_out), 64'(0));
      check("stall_count", 64'(count),       64'(20));
      check("stall_total", 64'(pkt_total),   64'(20));
      pop_check("stall_pop");
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         ok = bus.Ack_out;
         if (!ok) @(negedge CLK);
      end
      check("stall_release_ack", 64'(ok), 64'(1));
      model_q.push_back(p);
      model_total++;
      check("stall_release_count", 64'(count), 64'(20));
      check("stall_release_full",  64'(full),  64'(1));
      bus.Send_in = 1'b0;
      for (int i = 0; i < 20 && bus.Ack_out; i++) @(negedge CLK);
      check("stall_ack_drop", 64'(bus.Ack_out), 64'(0));
      for (int i = 0; i < 20; i++) pop_check($sformatf("stall_drain%0d", i));
      check("stall_drained", 64'(bus.empty), 64'(1));
      check("stall_total_end", 64'(pkt_total), 64'(model_total));

      // Random stream with frequent pops; model is a plain queue.
      sstate = 0;
      sent   = 0;
      cyc    = 0;
      while ((sent < 40 || sstate != 0) && cyc < 4000) begin
         @(negedge CLK);
         cyc++;
         if (sstate == 1 && bus.Ack_out) begin
            if (cur.hdr == HDR_OK) begin
               model_q.push_back(cur);
               model_total++;
            end else begin
               model_err = 1'b1;
            end
            bus.Send_in = 1'b0;
            sstate = 2;
         end else if (sstate == 2 && !bus.Ack_out) begin
            sstate = 0;
         end else if (sstate == 0 && sent < 40) begin
            cur = rnd_pkt();
            bus.PACKET_IN = cur;
            bus.Send_in   = 1'b1;
            sent++;
            sstate = 1;
         end
         check("stream_count", 64'(count), 64'(model_q.size()));
         bus.rd_en = ($urandom_range(0, 3) != 0);
         if (bus.rd_en) begin
            if (model_q.size() != 0) begin
               check("stream_data", 64'(bus.rd_data), 64'(model_q[0]));
               void'(model_q.pop_front());
            end else begin
               check("stream_empty", 64'(bus.empty), 64'(1));
            end
         end
      end
      @(negedge CLK);
      bus.rd_en = 1'b0;
      check("stream_done", 64'((sent == 40) && (sstate == 0)), 64'(1));
      while (model_q.size() != 0) pop_check("stream_drain");
      check("stream_total", 64'(pkt_total), 64'(16'(model_total)));
      check("stream_err",   64'(hdr_err),   64'(model_err));

      // Request held high across reset release must not be captured.
      bus.PACKET_IN = mk(3'b111, 8'd1, 7'd1, 4'd1, 16'h1111);
      bus.Send_in   = 1'b1;
      do_reset();
      repeat (8) @(negedge CLK);
      check("held_ack",   64'(bus.Ack_out), 64'(0));
      check("held_count", 64'(count),       64'(0));
      bus.Send_in = 1'b0;
      repeat (4) @(negedge CLK);
      send(mk(3'b111, 8'd2, 7'd2, 4'd2, 16'h2222), ok);
      check("held_rearm_ack",   64'(ok),    64'(1));
      check("held_rearm_count", 64'(count), 64'(1));

      // Reset in the middle of an acknowledged handshake.
      bus.PACKET_IN = mk(3'b111, 8'd3, 7'd3, 4'd3, 16'h3333);
      bus.Send_in   = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge CLK);
         ok = bus.Ack_out;
      end
      check("mid_ack_up", 64'(ok), 64'(1));
      #2 RST = 1'b1;
      #1;
      check("mid_ack_async", 64'(bus.Ack_out), 64'(0));
      check("mid_count",     64'(count),       64'(0));
      check("mid_total",     64'(pkt_total),   64'(0));
      check("mid_empty",     64'(bus.empty),   64'(1));
      @(negedge CLK);
      RST = 1'b0;
      bus.Send_in = 1'b0;
      model_clear();
      repeat (4) @(negedge CLK);
      p = mk(3'b111, 8'd4, 7'd4, 4'd4, 16'h4444);
      send(p, ok);
      check("post_rst_ack",   64'(ok),        64'(1));
      check("post_rst_count", 64'(count),     64'(1));
      check("post_rst_total", 64'(pkt_total), 64'(1));
      pop_check("post_rst_pop");
      check("post_rst_empty", 64'(bus.empty), 64'(1));

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
